// File: rtl/mnist_img_loader.sv
// mnist_img_loader: byte-stream image loader for the MNIST accelerator.
// Packs one IMG_SIZE-pixel frame from a valid/ready stream into a flat
// image bus. It pulses accel_start once the frame is complete. It captures
// the prediction on the rising edge of accel_done and returns that
// prediction over a valid/ready result handshake. A malformed frame (short
// or long) pulses err_frame.
// Optional build macro: MNIST_LOADER_WDOG_EN adds a WAIT-state watchdog.
// When the watchdog expires, the loader reports digit 4'hF and pulses
// err_frame.
module mnist_img_loader #(
    parameter int IMG_SIZE = 784,
    parameter int PIX_W    = 8,
    parameter int CNT_W    = 10,
    parameter int WDOG_CYC = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    input  logic [PIX_W-1:0]          s_data,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [IMG_SIZE*PIX_W-1:0] img_data,
    output logic                      accel_start,
    input  logic                      accel_done,
    input  logic [3:0]                pred_digit,
    output logic                      res_valid,
    output logic [3:0]                res_digit,
    input  logic                      res_ready,
    output logic                      err_frame,
    output logic                      busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESULT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_SIZE - 1);

    state_t                      state_r, state_s;
    logic [CNT_W-1:0]            cnt_r, cnt_s;
    logic [IMG_SIZE*PIX_W-1:0]   img_data_r;
    logic                        wr_en_s;
    logic                        s_ready_r;
    logic                        accel_start_r;
    logic                        res_valid_r, res_valid_s;
    logic [3:0]                  res_digit_r, res_digit_s;
    logic                        err_frame_r, err_s;
    logic                        busy_r;
    logic                        done_q_r;
    logic                        beat_s;
    logic                        done_rise_s;

    assign beat_s      = s_valid && s_ready_r;
    assign done_rise_s = accel_done && !done_q_r;

`ifdef MNIST_LOADER_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_r;

    // Watchdog: cleared while in START (entry to WAIT), counts WAIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_r <= {WD_W{1'b0}};
        end else if (state_r == ST_START) begin
            wdog_r <= {WD_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            wdog_r <= wdog_r + WD_W'(1);
        end
    end
`endif

    // Next-state, counter, pixel write enable and result/error decisions.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        wr_en_s     = 1'b0;
        err_s       = 1'b0;
        res_valid_s = res_valid_r;
        res_digit_s = res_digit_r;
        case (state_r)
            ST_IDLE: begin
                if (beat_s) begin
                    wr_en_s = 1'b1;
                    if (s_last && (IMG_SIZE > 1)) begin
                        err_s = 1'b1;
                        cnt_s = {CNT_W{1'b0}};
                    end else if (s_last) begin
                        state_s = ST_START;
                    end else if (IMG_SIZE == 1) begin
                        state_s = ST_DRAIN;
                    end else begin
                        cnt_s   = CNT_W'(1);
                        state_s = ST_RECV;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (beat_s) begin
                    wr_en_s = 1'b1;
                    if (cnt_r == LAST_IDX) begin
                        // Counter is left at the last index so DRAIN cannot
                        // address a pixel beyond the frame.
                        if (s_last) begin
                            state_s = ST_START;
                        end else begin
                            state_s = ST_DRAIN;
                        end
                    end else if (s_last) begin
                        err_s   = 1'b1;
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = ST_RECV;
                end
            end
            ST_DRAIN: begin
                if (beat_s && s_last) begin
                    err_s   = 1'b1;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_START: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise_s) begin
                    res_digit_s = pred_digit;
                    res_valid_s = 1'b1;
                    state_s     = ST_RESULT;
                end
`ifdef MNIST_LOADER_WDOG_EN
                else if (wdog_r == WD_W'(WDOG_CYC - 1)) begin
                    res_digit_s = 4'hF;
                    res_valid_s = 1'b1;
                    err_s       = 1'b1;
                    state_s     = ST_RESULT;
                end
`endif
                else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESULT: begin
                if (res_valid_r && res_ready) begin
                    res_valid_s = 1'b0;
                    cnt_s       = {CNT_W{1'b0}};
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_RESULT;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cnt_s       = {CNT_W{1'b0}};
                res_valid_s = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            s_ready_r     <= 1'b1;
            accel_start_r <= 1'b0;
            res_valid_r   <= 1'b0;
            res_digit_r   <= 4'h0;
            err_frame_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_q_r      <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            s_ready_r     <= (state_s == ST_IDLE) || (state_s == ST_RECV) ||
                             (state_s == ST_DRAIN);
            accel_start_r <= (state_s == ST_START);
            res_valid_r   <= res_valid_s;
            res_digit_r   <= res_digit_s;
            err_frame_r   <= err_s;
            busy_r        <= (state_s != ST_IDLE);
            done_q_r      <= accel_done;
        end
    end

    // Image buffer: an accepted IDLE/RECV beat writes the pixel at the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_data_r <= {(IMG_SIZE*PIX_W){1'b0}};
        end else begin
            for (int i = 0; i < IMG_SIZE; i++) begin
                if (wr_en_s && (cnt_r == CNT_W'(i))) begin
                    img_data_r[i*PIX_W +: PIX_W] <= s_data;
                end
            end
        end
    end

    assign s_ready     = s_ready_r;
    assign img_data    = img_data_r;
    assign accel_start = accel_start_r;
    assign res_valid   = res_valid_r;
    assign res_digit   = res_digit_r;
    assign err_frame   = err_frame_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_mnist_img_loader.sv
// Scoreboard bench for mnist_img_loader: the stimulus pushes expected results,
// expected error pulses and expected start pulses; a negedge monitor consumes them.
module tb_mnist_img_loader;
    localparam int IMG = 784;
    localparam int PW  = 8;
    localparam int CW  = 10;
`ifdef MNIST_LOADER_WDOG_EN
    localparam int WD = 16;
`else
    localparam int WD = 4096;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid;
    logic [PW-1:0]     s_data;
    logic              s_last;
    logic              s_ready;
    logic [IMG*PW-1:0] img_data;
    logic              accel_start;
    logic              accel_done;
    logic [3:0]        pred_digit;
    logic              res_valid;
    logic [3:0]        res_digit;
    logic              res_ready;
    logic              err_frame;
    logic              busy;

    mnist_img_loader #(.IMG_SIZE(IMG), .PIX_W(PW), .CNT_W(CW), .WDOG_CYC(WD)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .img_data(img_data),
        .accel_start(accel_start), .accel_done(accel_done),
        .pred_digit(pred_digit), .res_valid(res_valid), .res_digit(res_digit),
        .res_ready(res_ready), .err_frame(err_frame), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int err_pend = 0;
    int start_pend = 0;
    logic [3:0] res_q[$];
    logic [IMG*PW-1:0] exp_img;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_img(input string name);
        checks++;
        if (img_data !== exp_img) begin
            errors++;
            for (int i = 0; i < IMG; i++) begin
                if (img_data[i*PW +: PW] !== exp_img[i*PW +: PW]) begin
                    $display("FAIL %s: pixel %0d got %0h expected %0h", name, i,
                             img_data[i*PW +: PW], exp_img[i*PW +: PW]);
                    break;
                end
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives n beats with data k+seed; s_last on beat last_at (-1 = none).
    task automatic send(input int n, input int last_at, input int seed);
        int guard;
        for (int k = 0; k < n; k++) begin
            s_valid = 1'b1;
            s_data  = 8'(k + seed);
            s_last  = (k == last_at);
            guard   = 0;
            while (!s_ready && guard < 2000) begin
                tick();
                guard++;
            end
            if (guard >= 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: beat %0d got s_ready=0 expected 1", k);
                break;
            end
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic build_img(input int seed);
        for (int k = 0; k < IMG; k++) exp_img[k*PW +: PW] = 8'(k + seed);
    endtask

    task automatic wait_res(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 500) begin
            tick();
            cyc++;
        end
        if (!res_valid) begin
            checks++;
            errors++;
            $display("FAIL res_timeout: got res_valid=0 expected 1");
        end
    endtask

    // Scoreboard monitor: consumes expectations whenever the DUT presents an output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid && res_ready) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL res_unexpected: got digit %0h expected none", res_digit);
                end else begin
                    logic [3:0] e;
                    e = res_q.pop_front();
                    if (res_digit !== e) begin
                        errors++;
                        $display("FAIL res_digit: got %0h expected %0h", res_digit, e);
                    end
                end
            end
            if (err_frame) begin
                checks++;
                if (err_pend == 0) begin
                    errors++;
                    $display("FAIL err_unexpected: got err_frame=1 expected 0");
                end else begin
                    err_pend--;
                end
            end
            if (accel_start) begin
                checks++;
                if (start_pend == 0 || err_frame) begin
                    errors++;
                    $display("FAIL start_unexpected: got accel_start=1 (err_frame=%0b) expected 0", err_frame);
                end else begin
                    start_pend--;
                end
            end
        end
    end

    initial begin
        int cyc;
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        accel_done = 1'b0; pred_digit = 4'h0; res_ready = 1'b1;
        exp_img = '0;
        #12;
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_accel_start", accel_start, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_digit", res_digit, 4'h0);
        chk("rst_err_frame", err_frame, 1'b0);
        chk_img("rst_img");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Full frame, prediction 6 fifty cycles after start.
        start_pend++;
        res_q.push_back(4'd6);
        send(IMG, IMG - 1, 0);
        chk("f1_start_latency", accel_start, 1'b1);
        chk("f1_busy", busy, 1'b1);
        chk("f1_s_ready_start", s_ready, 1'b0);
        build_img(0);
        chk_img("f1_img");
        tick();
        chk("f1_start_one_cycle", accel_start, 1'b0);
        repeat (49) tick();
        pred_digit = 4'd6;
        accel_done = 1'b1;
        wait_res(cyc);
        chk("f1_res_digit", res_digit, 4'd6);
        chk("f1_busy_result", busy, 1'b1);
        tick();
        chk("f1_idle_busy", busy, 1'b0);
        chk("f1_idle_s_ready", s_ready, 1'b1);
        accel_done = 1'b0;

        // Short frame: s_last on beat 99, then a good frame with digit 2.
        err_pend++;
        send(100, 99, 7);
        chk("short_err", err_frame, 1'b1);
        chk("short_idle", busy, 1'b0);
        tick();
        chk("short_err_pulse", err_frame, 1'b0);
        start_pend++;
        res_q.push_back(4'd2);
        send(IMG, IMG - 1, 3);
        build_img(3);
        chk_img("f2_img");
        repeat (5) tick();
        pred_digit = 4'd2;
        accel_done = 1'b1;
        wait_res(cyc);
        tick();
        accel_done = 1'b0;

        // Long frame: 800 beats, beats 784..799 dropped.
        err_pend++;
        send(800, 799, 8'h55);
        chk("long_err", err_frame, 1'b1);
        chk("long_idle", busy, 1'b0);
        build_img(8'h55);
        chk_img("long_img");
        tick();

        // Stale accel_done level must not count as a result.
        pred_digit = 4'd5;
        accel_done = 1'b1;
        res_ready  = 1'b0;
        start_pend++;
        res_q.push_back(4'd3);
        send(IMG, IMG - 1, 1);
        repeat (10) tick();
        chk("stale_done_no_capture", res_valid, 1'b0);
        accel_done = 1'b0;
        repeat (2) tick();
        pred_digit = 4'd3;
        accel_done = 1'b1;
        wait_res(cyc);
        for (int i = 0; i < 20; i++) begin
            chk("hold_res_valid", res_valid, 1'b1);
            chk("hold_res_digit", res_digit, 4'd3);
            chk("hold_s_ready", s_ready, 1'b0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        chk("hs_s_ready", s_ready, 1'b1);
        chk("hs_res_valid", res_valid, 1'b0);
        accel_done = 1'b0;

        // No accelerator response.
        start_pend++;
        send(IMG, IMG - 1, 2);
`ifdef MNIST_LOADER_WDOG_EN
        err_pend++;
        res_q.push_back(4'hF);
        wait_res(cyc);
        chk("wdog_latency", cyc, 17);
        chk("wdog_digit", res_digit, 4'hF);
        tick();
`else
        repeat (100) tick();
        chk("wait_forever_valid", res_valid, 1'b0);
        chk("wait_forever_busy", busy, 1'b1);
        res_q.push_back(4'd9);
        pred_digit = 4'd9;
        accel_done = 1'b1;
        wait_res(cyc);
        tick();
        accel_done = 1'b0;
`endif

        // Asynchronous reset during beat 400.
        send(400, -1, 4);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_s_ready", s_ready, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_res_digit", res_digit, 4'h0);
        chk("arst_res_valid", res_valid, 1'b0);
        exp_img = '0;
        chk_img("arst_img");
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        chk("sb_res_left", res_q.size(), 0);
        chk("sb_err_left", err_pend, 0);
        chk("sb_start_left", start_pend, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
